// File: rtl/dct8_pkg.sv
// rtl/dct8_pkg.sv - coefficient table, fixed-point constants and FSM state type for dct8_ts_gen
package dct8_pkg;

    localparam int COEF_FRAC = 13;
    localparam int CONST_W   = 15;

    // COEF[k][i] = round(a_k * cos((2i+1)k*pi/16) * 2^13), i = 0..3
    localparam logic signed [CONST_W-1:0] COEF [8][4] = '{
        '{ 15'sd2896,  15'sd2896,  15'sd2896,  15'sd2896},
        '{ 15'sd4017,  15'sd3406,  15'sd2276,  15'sd799 },
        '{ 15'sd3784,  15'sd1567, -15'sd1567, -15'sd3784},
        '{ 15'sd3406, -15'sd799,  -15'sd4017, -15'sd2276},
        '{ 15'sd2896, -15'sd2896, -15'sd2896,  15'sd2896},
        '{ 15'sd2276, -15'sd4017,  15'sd799,   15'sd3406},
        '{ 15'sd1567, -15'sd3784,  15'sd3784, -15'sd1567},
        '{ 15'sd799,  -15'sd2276,  15'sd3406, -15'sd4017}
    };

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

endpackage

// File: rtl/dct8_mac_lane.sv
// rtl/dct8_mac_lane.sv - one LUT multiplier with job decode: job = ph*NUM_MUL + LANE -> k = job/4, i = job%4
module dct8_mac_lane
    import dct8_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int NUM_MUL = 8,
    parameter int LANE    = 0,
    parameter int PH_W    = 2
) (
    input  logic [PH_W-1:0]              ph_i,
    input  logic signed [IN_W:0]         s_i [4],
    input  logic signed [IN_W:0]         d_i [4],
    output logic [2:0]                   k_o,
    output logic signed [IN_W+CONST_W:0] prod_o
);

    localparam int PROD_W = IN_W + 1 + CONST_W;

    logic [4:0]                job;
    logic signed [IN_W:0]      v;
    logic signed [CONST_W-1:0] coef;

    (* use_dsp = "no" *) logic signed [PROD_W-1:0] prod;

    assign job  = 5'(ph_i) * 5'(NUM_MUL) + 5'(LANE);
    assign k_o  = job[4:2];
    assign coef = COEF[job[4:2]][job[1:0]];
    // Odd coefficients use the butterfly differences, even ones the sums.
    assign v    = job[2] ? d_i[job[1:0]] : s_i[job[1:0]];
    assign prod = PROD_W'(v) * PROD_W'(coef);

    assign prod_o = prod;

endmodule

// File: rtl/dct8_ts_gen.sv
// rtl/dct8_ts_gen.sv - 8-point 1-D forward DCT over NUM_MUL time-shared multipliers with decoupled output slot
// DCT8_ROUND_EN: when defined, add 2^12 before the final shift (round half up); otherwise truncate.
module dct8_ts_gen
    import dct8_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int NUM_MUL = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7,
    output logic                   out_sat
);

    localparam int NPH    = 32 / NUM_MUL;
    localparam int PH_W   = (NPH > 1) ? $clog2(NPH) : 1;
    localparam int V_W    = IN_W + 1;
    localparam int PROD_W = V_W + CONST_W;
    localparam int ACC_W  = IN_W + 1 + CONST_W + 2;

    localparam logic [PH_W-1:0]         PH_LAST = PH_W'(NPH - 1);
    localparam logic signed [ACC_W-1:0] MAX_V   = ACC_W'((longint'(1) << (IN_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V   = -MAX_V - ACC_W'(1);
`ifdef DCT8_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (COEF_FRAC - 1));
`else
    localparam logic signed [ACC_W-1:0] RND     = '0;
`endif

    if (NUM_MUL != 4 && NUM_MUL != 8 && NUM_MUL != 16 && NUM_MUL != 32) begin : g_bad_num_mul
        $error("dct8_ts_gen: NUM_MUL must be 4, 8, 16 or 32");
    end

    state_t                    state_q;
    logic                      in_ready_q, out_valid_q, out_sat_q;
    logic [PH_W-1:0]           ph_q;
    logic signed [V_W-1:0]     s_q [4];
    logic signed [V_W-1:0]     d_q [4];
    logic signed [V_W-1:0]     s_d [4];
    logic signed [V_W-1:0]     d_d [4];
    logic signed [ACC_W-1:0]   acc_q [8];
    logic signed [ACC_W-1:0]   acc_d [8];
    logic signed [IN_W-1:0]    out_q [8];
    logic signed [IN_W-1:0]    fin [8];
    logic                      fin_sat;
    logic signed [IN_W-1:0]    x [8];
    logic [2:0]                lane_k [NUM_MUL];
    logic signed [PROD_W-1:0]  prod [NUM_MUL];
    logic                      slot_free;

    assign x = '{in0, in1, in2, in3, in4, in5, in6, in7};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_d[i] = V_W'(x[i]) + V_W'(x[7-i]);
            d_d[i] = V_W'(x[i]) - V_W'(x[7-i]);
        end
    end

    for (genvar m = 0; m < NUM_MUL; m++) begin : g_lane
        dct8_mac_lane #(
            .IN_W    (IN_W),
            .NUM_MUL (NUM_MUL),
            .LANE    (m),
            .PH_W    (PH_W)
        ) u_lane (
            .ph_i   (ph_q),
            .s_i    (s_q),
            .d_i    (d_q),
            .k_o    (lane_k[m]),
            .prod_o (prod[m])
        );
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc_d[k] = acc_q[k];
            for (int m = 0; m < NUM_MUL; m++) begin
                if (lane_k[m] == 3'(k)) acc_d[k] = acc_d[k] + ACC_W'(prod[m]);
            end
        end
    end

    // On the last phase the sums still include this cycle's products; in S_HOLD they are frozen.
    always_comb begin
        logic signed [ACC_W-1:0] src;
        logic signed [ACC_W-1:0] sh;
        fin_sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
            src = (state_q == S_HOLD) ? acc_q[k] : acc_d[k];
            sh  = (src + RND) >>> COEF_FRAC;
            if (sh > MAX_V) begin
                fin[k]  = MAX_V[IN_W-1:0];
                fin_sat = 1'b1;
            end else if (sh < MIN_V) begin
                fin[k]  = MIN_V[IN_W-1:0];
                fin_sat = 1'b1;
            end else begin
                fin[k]  = sh[IN_W-1:0];
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            ph_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                d_q[i] <= '0;
            end
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        s_q        <= s_d;
                        d_q        <= d_d;
                        for (int k = 0; k < 8; k++) acc_q[k] <= '0;
                        ph_q       <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    ph_q  <= ph_q + PH_W'(1);
                    if (ph_q == PH_LAST) begin
                        if (slot_free) begin
                            out_q       <= fin;
                            out_sat_q   <= fin_sat;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        out_q       <= fin;
                        out_sat_q   <= fin_sat;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
    assign out4 = out_q[4];
    assign out5 = out_q[5];
    assign out6 = out_q[6];
    assign out7 = out_q[7];

endmodule

// File: tb/tb_dct8_ts_gen.sv
// tb/tb_dct8_ts_gen.sv - directed self-checking bench for dct8_ts_gen (IN_W=16/NUM_MUL=8 main, IN_W=24 NUM_MUL sweep)
`timescale 1ns/1ps
module tb_dct8_ts_gen;

    typedef longint row_t [8];
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_sat;
    logic signed [W-1:0] din [8];
    logic signed [W-1:0] dout [8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dct8_ts_gen #(.IN_W(W), .NUM_MUL(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
        .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7]),
        .out_sat(out_sat)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Integer reference: coefficients derived from the cosine definition, not from the RTL table.
    function automatic void model(input int w, input row_t x, output row_t y, output bit sat);
        longint acc, v, c, hi, lo;
        real a;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            a = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
            for (int i = 0; i < 4; i++) begin
                c = longint'($floor(a * $cos(real'((2 * i + 1) * k) * 3.14159265358979 / 16.0) * 8192.0 + 0.5));
                v = (k % 2 == 1) ? x[i] - x[7-i] : x[i] + x[7-i];
                acc += c * v;
            end
`ifdef DCT8_ROUND_EN
            acc += 4096;
`endif
            acc = acc >>> 13;
            if (acc > hi) begin acc = hi; sat = 1'b1; end
            else if (acc < lo) begin acc = lo; sat = 1'b1; end
            y[k] = acc;
        end
    endfunction

    function automatic longint rnd(input int w);
        return longint'($urandom_range((1 << w) - 1, 0)) - (longint'(1) << (w - 1));
    endfunction

    longint got_v[$];
    bit     got_s[$];
    int     got_t[$];
    longint exp_v[$];
    bit     exp_s[$];

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            for (int k = 0; k < 8; k++) got_v.push_back(longint'(dout[k]));
            got_s.push_back(out_sat);
            got_t.push_back(cyc);
        end
    end

    task automatic clear_q();
        got_v.delete(); got_s.delete(); got_t.delete();
        exp_v.delete(); exp_s.delete();
    endtask

    task automatic expect_row(input row_t x);
        row_t y;
        bit s;
        model(W, x, y, s);
        for (int k = 0; k < 8; k++) exp_v.push_back(y[k]);
        exp_s.push_back(s);
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge with in_valid low.
    task automatic send(input row_t x, input int budget, output int hs_cyc);
        bit ok;
        ok = 1'b0;
        hs_cyc = -1;
        for (int k = 0; k < 8; k++) din[k] = W'(x[k]);
        in_valid = 1'b1;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                hs_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_rows(input int n, input int budget);
        int c;
        c = 0;
        while (got_s.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("rows_arrived", got_s.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic compare_rows(input string tag);
        check($sformatf("%s_count", tag), got_s.size(), exp_s.size());
        for (int r = 0; r < exp_s.size() && r < got_s.size(); r++) begin
            for (int k = 0; k < 8; k++)
                check($sformatf("%s_r%0d_x%0d", tag, r, k), got_v[r*8+k], exp_v[r*8+k]);
            check($sformatf("%s_r%0d_sat", tag, r), got_s[r], exp_s[r]);
        end
        clear_q();
    endtask

    // Width-24 instances across all legal NUM_MUL values, each with its own reset and handshake.
    for (genvar g = 0; g < 4; g++) begin : g_var
        localparam int NM = 4 << g;
        localparam int NP = 32 / NM;
        logic v_rst_n, v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_out_sat;
        logic signed [23:0] v_in [8];
        logic signed [23:0] v_out [8];
        bit done = 1'b0;

        dct8_ts_gen #(.IN_W(24), .NUM_MUL(NM)) u_dut (
            .clk(clk), .rst_n(v_rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
            .in0(v_in[0]), .in1(v_in[1]), .in2(v_in[2]), .in3(v_in[3]),
            .in4(v_in[4]), .in5(v_in[5]), .in6(v_in[6]), .in7(v_in[7]),
            .out_valid(v_out_valid), .out_ready(v_out_ready),
            .out0(v_out[0]), .out1(v_out[1]), .out2(v_out[2]), .out3(v_out[3]),
            .out4(v_out[4]), .out5(v_out[5]), .out6(v_out[6]), .out7(v_out[7]),
            .out_sat(v_out_sat)
        );

        initial begin
            row_t rows [4];
            row_t y;
            bit s, hs;
            int sent, rcvd, t0, last;
            v_rst_n = 1'b0; v_in_valid = 1'b0; v_out_ready = 1'b1;
            for (int k = 0; k < 8; k++) v_in[k] = '0;
            rows[0] = '{default: 25600};
            for (int r = 1; r < 4; r++)
                for (int k = 0; k < 8; k++) rows[r][k] = rnd(24);
            repeat (2) @(posedge clk);
            #1 v_rst_n = 1'b1;
            sent = 0; rcvd = 0; t0 = 0; last = 0;
            for (int k = 0; k < 8; k++) v_in[k] = 24'(rows[0][k]);
            v_in_valid = 1'b1;
            for (int c = 0; c < 200 && rcvd < 4; c++) begin
                @(negedge clk);
                if (v_out_valid) begin
                    if (rcvd == 0) begin
                        check($sformatf("v%0d_latency", NM), c - t0, NP + 1);
                        for (int k = 0; k < 8; k++)
                            check($sformatf("v%0d_dc_x%0d", NM, k), longint'(v_out[k]), (k == 0) ? 72400 : 0);
                        check($sformatf("v%0d_dc_sat", NM), v_out_sat, 0);
                    end else begin
                        check($sformatf("v%0d_spacing%0d", NM, rcvd), c - last, NP + 1);
                        model(24, rows[rcvd], y, s);
                        for (int k = 0; k < 8; k++)
                            check($sformatf("v%0d_r%0d_x%0d", NM, rcvd, k), longint'(v_out[k]), y[k]);
                        check($sformatf("v%0d_r%0d_sat", NM, rcvd), v_out_sat, s);
                    end
                    last = c;
                    rcvd++;
                end
                hs = v_in_valid && v_in_ready;
                if (hs && sent == 0) t0 = c;
                @(posedge clk); #1;
                if (hs) begin
                    sent++;
                    if (sent < 4) for (int k = 0; k < 8; k++) v_in[k] = 24'(rows[sent][k]);
                    else v_in_valid = 1'b0;
                end
            end
            check($sformatf("v%0d_rows", NM), rcvd, 4);
            done = 1'b1;
        end
    end

    initial begin
        row_t x, r1, r2, r3;
        int hs, hs3;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) din[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out0", dout[0], 0);
        check("rst_out_sat", out_sat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        x = '{5, 0, 0, 0, 0, 0, 0, 0};
        send(x, 20, hs);
        wait_rows(1, 20);
        if (got_s.size() > 0) begin
            check("latency", got_t[0] - hs, 5);
`ifdef DCT8_ROUND_EN
            check("round_x0", got_v[0], 2);
`else
            check("round_x0", got_v[0], 1);
`endif
        end
        expect_row(x);
        compare_rows("round");

        x = '{default: 32767};
        send(x, 20, hs);
        wait_rows(1, 20);
        if (got_s.size() > 0) begin
            check("sat_x0", got_v[0], 32767);
            check("sat_x1", got_v[1], 0);
            check("sat_flag", got_s[0], 1);
        end
        clear_q();
        x = '{100, -200, 300, -400, 500, -600, 700, -800};
        expect_row(x);
        send(x, 20, hs);
        wait_rows(1, 20);
        if (got_s.size() > 0) check("sat_cleared", got_s[0], 0);
        compare_rows("after_sat");

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) x[k] = rnd(W);
            expect_row(x);
            send(x, 20, hs);
        end
        wait_rows(4, 40);
        for (int r = 1; r < 4 && r < got_t.size(); r++)
            check($sformatf("stream_spacing%0d", r), got_t[r] - got_t[r-1], 5);
        compare_rows("stream");

        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r1[k] = rnd(W); r2[k] = rnd(W); r3[k] = rnd(W);
        end
        expect_row(r1); expect_row(r2); expect_row(r3);
        send(r1, 20, hs);
        send(r2, 20, hs);
        fork
            send(r3, 100, hs3);
            begin
                repeat (20) @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_hold_x0", dout[0], exp_v[0]);
                check("bp_hold_x7", dout[7], exp_v[7]);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_rows(3, 60);
        compare_rows("bp");

        out_ready = 1'b0;
        x = '{1000, 2000, 3000, 4000, -1000, -2000, -3000, -4000};
        send(x, 20, hs);
        send(x, 20, hs);
        @(posedge clk); #1;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out0", dout[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_q();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) x[k] = rnd(W);
        expect_row(x);
        send(x, 20, hs);
        wait_rows(1, 20);
        compare_rows("post_rst");

        for (int c = 0; c < 3000 && !(g_var[0].done && g_var[1].done && g_var[2].done && g_var[3].done); c++)
            @(negedge clk);
        check("variants_done", {g_var[3].done, g_var[2].done, g_var[1].done, g_var[0].done}, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct8_ts_gen.md
# dct8_ts_gen

Parametrised 8-point 1-D forward DCT with a time-shared multiplier bank. It sits in the JPEG preprocess path between the level-shift stage and the row/column transpose buffer. Each input row of 8 fixed-point samples is reduced to 8 orthonormal DCT coefficients using NUM_MUL LUT multipliers over 32/NUM_MUL cycles. A decoupled output register lets the next row be computed while the downstream stage holds back.

## Interface
- IN_W, 16: signed sample/coefficient width, in and out (≥ 8)
- NUM_MUL, 8: parallel multipliers; legal values 4, 8, 16, 32; any other value is an elaboration $error
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  row present
- in_ready  out  1  engine can accept a row
- in0..in7  in  IN_W each  signed samples
- out_valid  out  1  coefficient row held
- out_ready  in  1  downstream accepts
- out0..out7  out  IN_W each  signed coefficients X[0..7]
- out_sat  out  1  at least one coefficient of the held row was saturated

## Operation
- Transform: X[k] = Σ_i COEF[k][i]·v_i >>> 13.
  - v_i = s_i = x_i + x_{7−i} for even k.
  - v_i = d_i = x_i − x_{7−i} for odd k.
  - i = 0..3.
- Coefficients:
  - COEF[k][i] = round(a_k·cos((2i+1)kπ/16)·2^13).
  - a_0 = 1/(2√2), a_k = 1/2 for k > 0.
  - Examples: COEF[0][*] = 2896; COEF[1][0] = 4017; COEF[2] = {3784, 1567, −1567, −3784}.
- Jobs: there are 32 multiply jobs. Job j = ph·NUM_MUL + m maps to k = j/4, i = j%4. ph is the phase counter; m is the multiplier index.
- Phase count: NPH = 32/NUM_MUL.
- Accumulators: 8 accumulators at full precision, width IN_W+1+15+2. They are cleared on capture.
- Finalisation: shift right by 13, then saturate to signed IN_W. Any clipping sets out_sat for that row.
- FSM states:
  - S_IDLE: in_ready = 1. On in_valid, register s0..s3 and d0..d3, clear the accumulators, ph = 0, go to S_CALC.
  - S_CALC: each cycle, NUM_MUL products are added into the accumulators and ph increments. On ph = NPH−1:
    - if the output slot is free (out_valid = 0, or out_ready = 1 this cycle), load out*/out_sat, set out_valid, go to S_IDLE;
    - otherwise go to S_HOLD.
  - S_HOLD: the accumulators are frozen. Load the output once the slot frees, then go to S_IDLE.
- Output slot:
  - out_valid clears on out_ready when no new load occurs in the same cycle.
  - A simultaneous pop and load keeps out_valid = 1 with the new data.
- Outputs are stable while out_valid = 1 and out_ready = 0.
- Reset mid-row discards the row and all accumulator contents.

## Timing
- Reset values: state S_IDLE, in_ready = 1, out_valid = 0, out0..out7 = 0, out_sat = 0.
- Latency, handshake at edge T0 to out_valid: 1 + NPH cycles. For NUM_MUL = 8, out_valid is high from T5.
- Throughput with out_ready held at 1: one row per 1 + NPH cycles. in_ready returns in the same cycle out_valid rises.
- Under backpressure:
  - one row sits in the output register and one in the engine (S_HOLD);
  - in_ready = 0 until the engine drains.
- The engine never overwrites an unread output row.

## Configuration
- DCT8_ROUND_EN defined: add 2^12 before the final >>> 13 (round half up).
- DCT8_ROUND_EN undefined: plain arithmetic-shift truncation toward −∞.
- Saturation is applied after the shift in both cases.

## Structure
- Package dct8_pkg holds:
  - COEF_FRAC = 13;
  - CONST_W = 15;
  - the COEF[8][4] localparam table;
  - the state_t enum {S_IDLE, S_CALC, S_HOLD}.
- Sub-module dct8_mac_lane: one multiplier (use_dsp = "no") plus job-index decode, instantiated NUM_MUL times.

## Test plan
- DC row: IN_W = 24, all inputs 25600, NUM_MUL = 8 -> out0 = 72400, out1..out7 = 0, out_sat = 0, out_valid at T5.
- Streaming: 4 random rows back-to-back with out_ready = 1 -> one row every 5 cycles, results match a bit-exact integer model. Repeat for NUM_MUL = 4/16/32 with NPH = 8/2/1.
- Backpressure: out_ready = 0 while 3 rows are offered -> rows 1 and 2 are accepted and row 2 parks in S_HOLD. in_ready stays 0. Releasing out_ready delivers rows 1, 2, 3 in order with no loss or duplication.
- Saturation: IN_W = 16, all inputs 32767 -> out0 = 32767, out_sat = 1. The next normal row gives out_sat = 0.
- Rounding: in0 = 5, others 0 -> out0 = 2 with DCT8_ROUND_EN, 1 without.
- Reset mid-S_CALC: assert rst_n low at ph = 1 -> immediately out_valid = 0, outputs 0, in_ready = 1. The next row computes correctly.
